mips_exec_core: RTL and testbench



---
 rtl/mips_pkg.sv | 45 ++++
 rtl/mips_exec_core_regfile.sv | 39 +++
 rtl/mips_exec_core.sv | 108 ++++++++++
 tb/tb_mips_exec_core.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and encodings for the MIPS single-cycle execute/write-back core.
package mips_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_addr_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F
    } opcode_e;

    typedef enum logic [5:0] {
        ALU_SLLV = 6'h04,
        ALU_SRLV = 6'h06,
        ALU_SRAV = 6'h07,
        ALU_ADD  = 6'h20,
        ALU_ADDU = 6'h21,
        ALU_SUB  = 6'h22,
        ALU_SUBU = 6'h23,
        ALU_AND  = 6'h24,
        ALU_OR   = 6'h25,
        ALU_XOR  = 6'h26,
        ALU_NOR  = 6'h27,
        ALU_SLT  = 6'h2A,
        ALU_SLTU = 6'h2B
    } alu_op_e;

    function automatic logic is_rtype_funct(input logic [5:0] funct);
        case (funct)
            6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_exec_core_regfile.sv
// 32x32 register file: combinational reads (old value on read-during-write), $0 hardwired to 0.
// MIPS_EXEC_DBG_PORT_EN adds a third read port for debug.
module exec_regfile
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      we,
    input  reg_addr_t waddr,
    input  word_t     wdata,
    input  reg_addr_t raddr_a,
    output word_t     rdata_a,
    input  reg_addr_t raddr_b,
    output word_t     rdata_b
`ifdef MIPS_EXEC_DBG_PORT_EN
    ,
    input  reg_addr_t raddr_dbg,
    output word_t     rdata_dbg
`endif
);

    word_t mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

`ifdef MIPS_EXEC_DBG_PORT_EN
    assign rdata_dbg = (raddr_dbg == '0) ? '0 : mem[raddr_dbg];
`endif

endmodule

// File: rtl/mips_exec_core.sv
// Single-cycle MIPS execute/write-back core: decode, register read, ALU, write-back next edge.
// MIPS_EXEC_DBG_PORT_EN exposes a debug register read port (dbg_addr/dbg_data).
module mips_exec_core
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic [31:0] alu_res,
    output logic        reg_write_en,
    output logic [4:0]  reg_w,
    output logic        illegal
`ifdef MIPS_EXEC_DBG_PORT_EN
    ,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
`endif
);

    logic [5:0] opcode;
    logic [5:0] funct;
    reg_addr_t  rs, rt, rd;
    logic [15:0] imm;
    word_t      rs_data, rt_data;
    word_t      imm_sext, imm_zext;
    word_t      a, b, res;
    alu_op_e    alu_op;
    logic       legal;

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0, imm};

    always_comb begin
        alu_op = ALU_ADD;
        a      = rs_data;
        b      = imm_sext;
        reg_w  = rt;
        legal  = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                alu_op = alu_op_e'(funct);
                b      = rt_data;
                reg_w  = rd;
                legal  = is_rtype_funct(funct);
            end
            OP_ADDI:  alu_op = ALU_ADD;
            OP_ADDIU: alu_op = ALU_ADDU;
            OP_SLTI:  alu_op = ALU_SLT;
            OP_SLTIU: alu_op = ALU_SLTU;
            OP_ANDI: begin alu_op = ALU_AND; b = imm_zext; end
            OP_ORI:  begin alu_op = ALU_OR;  b = imm_zext; end
            OP_XORI: begin alu_op = ALU_XOR; b = imm_zext; end
            OP_LUI: begin
                alu_op = ALU_OR;
                a      = '0;
                b      = {imm, 16'h0};
            end
            default: legal = 1'b0;
        endcase
    end

    // Adds and subtracts wrap silently; ADD and ADDU are the same datapath.
    always_comb begin
        res = '0;
        case (alu_op)
            ALU_ADD, ALU_ADDU: res = a + b;
            ALU_SUB, ALU_SUBU: res = a - b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_SLT:  res = {31'h0, $signed(a) < $signed(b)};
            ALU_SLTU: res = {31'h0, a < b};
            ALU_SLLV: res = b << a[4:0];
            ALU_SRLV: res = b >> a[4:0];
            ALU_SRAV: res = word_t'($signed(b) >>> a[4:0]);
            default:  res = '0;
        endcase
    end

    assign alu_res      = legal ? res : '0;
    assign illegal      = ~legal;
    assign reg_write_en = legal & ~reset;

    exec_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we        (reg_write_en),
        .waddr     (reg_w),
        .wdata     (alu_res),
        .raddr_a   (rs),
        .rdata_a   (rs_data),
        .raddr_b   (rt),
        .rdata_b   (rt_data)
`ifdef MIPS_EXEC_DBG_PORT_EN
        ,
        .raddr_dbg (dbg_addr),
        .rdata_dbg (dbg_data)
`endif
    );

endmodule

// File: tb/tb_mips_exec_core.sv
// Directed-vector bench for mips_exec_core; register contents are read back by issuing ADDU $0,$r,$0.
module tb_mips_exec_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        next_reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic [31:0] alu_res;
    logic        reg_write_en;
    logic [4:0]  reg_w;
    logic        illegal;
`ifdef MIPS_EXEC_DBG_PORT_EN
    logic [4:0]  dbg_addr = 5'd1;
    logic [31:0] dbg_data;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    mips_exec_core dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .alu_res      (alu_res),
        .reg_write_en (reg_write_en),
        .reg_w        (reg_w),
        .illegal      (illegal)
`ifdef MIPS_EXEC_DBG_PORT_EN
        ,
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] f, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'h00, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // driver: apply one instruction at the falling edge, check mid-low-phase
    task automatic step(input string tag, input logic [31:0] i, input logic [31:0] exp_res,
                        input logic exp_we, input logic [4:0] exp_w, input logic exp_ill);
        @(negedge clk);
        reset = next_reset;
        instr = i;
        #2;
        exp_q.push_back(exp_res);
        exp_q.push_back({31'h0, exp_we});
        exp_q.push_back({27'h0, exp_w});
        exp_q.push_back({31'h0, exp_ill});
        check({tag, ".res"}, alu_res, exp_q.pop_front());
        check({tag, ".we"},  {31'h0, reg_write_en}, exp_q.pop_front());
        check({tag, ".w"},   {27'h0, reg_w}, exp_q.pop_front());
        check({tag, ".ill"}, {31'h0, illegal}, exp_q.pop_front());
    endtask

    task automatic rd_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        step(tag, r_ins(6'h21, 5'd0, r, 5'd0), exp, 1'b1, 5'd0, 1'b0);
    endtask

    initial begin
        // reset held for two cycles; write-back suppressed
        step("rst0", i_ins(6'h08, 5'd1, 5'd0, 16'd9), 32'd9, 1'b0, 5'd1, 1'b0);
        step("rst1", i_ins(6'h08, 5'd1, 5'd0, 16'd9), 32'd9, 1'b0, 5'd1, 1'b0);
        next_reset = 1'b0;
        rd_reg("rst_r1", 5'd1, 32'd0);

        step("addi1", i_ins(6'h08, 5'd1, 5'd0, 16'd5), 32'd5, 1'b1, 5'd1, 1'b0);
`ifdef MIPS_EXEC_DBG_PORT_EN
        @(negedge clk);
        #2;
        check("dbg_r1", dbg_data, 32'd5);
        dbg_addr = 5'd0;
        #1;
        check("dbg_r0", dbg_data, 32'd0);
`endif
        rd_reg("r1", 5'd1, 32'd5);
        step("addi2", i_ins(6'h08, 5'd2, 5'd0, 16'hFFFD), 32'hFFFF_FFFD, 1'b1, 5'd2, 1'b0);
        step("add3",  r_ins(6'h20, 5'd3, 5'd1, 5'd2), 32'd2, 1'b1, 5'd3, 1'b0);
        step("sub4",  r_ins(6'h22, 5'd4, 5'd2, 5'd1), 32'hFFFF_FFF8, 1'b1, 5'd4, 1'b0);
        rd_reg("r3", 5'd3, 32'd2);
        rd_reg("r4", 5'd4, 32'hFFFF_FFF8);

        // signed overflow wraps without trapping
        step("lui5",  i_ins(6'h0F, 5'd5, 5'd0, 16'h7FFF), 32'h7FFF_0000, 1'b1, 5'd5, 1'b0);
        step("ori5",  i_ins(6'h0D, 5'd5, 5'd5, 16'hFFFF), 32'h7FFF_FFFF, 1'b1, 5'd5, 1'b0);
        step("ovf5",  i_ins(6'h08, 5'd5, 5'd5, 16'd1), 32'h8000_0000, 1'b1, 5'd5, 1'b0);
        step("dbl5",  r_ins(6'h20, 5'd5, 5'd5, 5'd5), 32'h0, 1'b1, 5'd5, 1'b0);
        step("acc5a", i_ins(6'h08, 5'd5, 5'd5, 16'h7FFF), 32'h0000_7FFF, 1'b1, 5'd5, 1'b0);
        step("acc5b", i_ins(6'h08, 5'd5, 5'd5, 16'h7FFF), 32'h0000_FFFE, 1'b1, 5'd5, 1'b0);

        step("slt6",  r_ins(6'h2A, 5'd6, 5'd2, 5'd1), 32'd1, 1'b1, 5'd6, 1'b0);
        step("sltu7", r_ins(6'h2B, 5'd7, 5'd2, 5'd1), 32'd0, 1'b1, 5'd7, 1'b0);
        step("slti",  i_ins(6'h0A, 5'd12, 5'd2, 16'hFFFE), 32'd1, 1'b1, 5'd12, 1'b0);
        step("sltiu", i_ins(6'h0B, 5'd13, 5'd1, 16'hFFFF), 32'd1, 1'b1, 5'd13, 1'b0);
        step("andi",  i_ins(6'h0C, 5'd11, 5'd2, 16'hFFFF), 32'h0000_FFFD, 1'b1, 5'd11, 1'b0);
        step("xori",  i_ins(6'h0E, 5'd14, 5'd2, 16'h00FF), 32'hFFFF_FF02, 1'b1, 5'd14, 1'b0);
        step("lui8",  i_ins(6'h0F, 5'd8, 5'd0, 16'h1234), 32'h1234_0000, 1'b1, 5'd8, 1'b0);
        rd_reg("r8", 5'd8, 32'h1234_0000);

        step("lui9",  i_ins(6'h0F, 5'd9, 5'd0, 16'h8000), 32'h8000_0000, 1'b1, 5'd9, 1'b0);
        step("addi10", i_ins(6'h08, 5'd10, 5'd0, 16'd4), 32'd4, 1'b1, 5'd10, 1'b0);
        step("srav",  r_ins(6'h07, 5'd15, 5'd10, 5'd9), 32'hF800_0000, 1'b1, 5'd15, 1'b0);
        step("srlv",  r_ins(6'h06, 5'd15, 5'd10, 5'd9), 32'h0800_0000, 1'b1, 5'd15, 1'b0);
        step("addi16", i_ins(6'h08, 5'd16, 5'd0, 16'd31), 32'd31, 1'b1, 5'd16, 1'b0);
        step("addi18", i_ins(6'h08, 5'd18, 5'd0, 16'd1), 32'd1, 1'b1, 5'd18, 1'b0);
        step("sllv",  r_ins(6'h04, 5'd17, 5'd16, 5'd18), 32'h8000_0000, 1'b1, 5'd17, 1'b0);

        step("nor",   r_ins(6'h27, 5'd19, 5'd0, 5'd0), 32'hFFFF_FFFF, 1'b1, 5'd19, 1'b0);
        step("and",   r_ins(6'h24, 5'd20, 5'd2, 5'd1), 32'd5, 1'b1, 5'd20, 1'b0);
        step("or",    r_ins(6'h25, 5'd20, 5'd1, 5'd10), 32'd5, 1'b1, 5'd20, 1'b0);
        step("xor",   r_ins(6'h26, 5'd20, 5'd1, 5'd10), 32'd1, 1'b1, 5'd20, 1'b0);
        step("subu",  r_ins(6'h23, 5'd20, 5'd1, 5'd2), 32'd8, 1'b1, 5'd20, 1'b0);
        step("addu",  r_ins(6'h21, 5'd20, 5'd20, 5'd20), 32'd16, 1'b1, 5'd20, 1'b0);

        // $0 stays zero even though a write is reported
        step("addi0", i_ins(6'h08, 5'd0, 5'd0, 16'd7), 32'd7, 1'b1, 5'd0, 1'b0);
        rd_reg("r0", 5'd0, 32'd0);

        // dependent pair: second reads the value written by the first
        step("dep_a", i_ins(6'h08, 5'd1, 5'd1, 16'd3), 32'd8, 1'b1, 5'd1, 1'b0);
        step("dep_b", i_ins(6'h08, 5'd1, 5'd1, 16'd3), 32'd11, 1'b1, 5'd1, 1'b0);

        step("lw_ill", i_ins(6'h23, 5'd1, 5'd0, 16'd4), 32'd0, 1'b0, 5'd1, 1'b1);
        step("jr_ill", r_ins(6'h08, 5'd1, 5'd10, 5'd0), 32'd0, 1'b0, 5'd1, 1'b1);
        rd_reg("r1_kept", 5'd1, 32'd11);

        // reset mid-stream discards the in-flight write and clears everything
        next_reset = 1'b1;
        step("rst_mid", i_ins(6'h08, 5'd1, 5'd0, 16'd9), 32'd9, 1'b0, 5'd1, 1'b0);
        next_reset = 1'b0;
        rd_reg("r1_clr", 5'd1, 32'd0);
        rd_reg("r2_clr", 5'd2, 32'd0);
        step("post_rst", r_ins(6'h22, 5'd3, 5'd9, 5'd10), 32'd0, 1'b1, 5'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
